// File: rtl/boa_csr_hpm.sv
// ----------------------------------------------------------------------------
// boa_csr_hpm
//
// Hardware performance-monitor CSR block: mcycle, minstret, mhpmcounter3..N,
// their high halves, the user-mode read-only shadows, mcounteren and
// mcountinhibit.
//
// Reads are purely combinational on addr. A write is applied on the next rising
// edge. A counter that is written in a cycle does not also increment in that
// cycle.
//
// Ports
//   clk     in   1          sole clock, all state on the rising edge
//   rst     in   1          asynchronous active-high reset
//   we      in   1          CSR write enable
//   addr    in   12         CSR address
//   wdata   in   32         CSR write data (already merged by the core)
//   exists  out  1          addr is decoded by this block
//   rdonly  out  1          addressed CSR is read-only
//   priv    out  2          minimum privilege level for the addressed CSR
//   rdata   out  32         read data (0 when not decoded)
//   retire  in   1          one instruction retired this cycle
//   evt     in   NUM_HPM    event pulses, bit i drives mhpmcounter(i+3)
//
// Handshake: there is none. we/addr/wdata are sampled on every rising edge,
// and the read outputs are valid in the same cycle that addr is presented.
// ----------------------------------------------------------------------------
module boa_csr_hpm #(
    parameter int NUM_HPM   = 4,
    parameter int CNT_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [11:0]        addr,
    input  logic [31:0]        wdata,
    output logic               exists,
    output logic               rdonly,
    output logic [1:0]         priv,
    output logic [31:0]        rdata,
    input  logic               retire,
    input  logic [NUM_HPM-1:0] evt
);

    // Implemented counter slots: 0 (mcycle), 2 (minstret) and 3..NUM_HPM+2.
    // Slot 1 (time) is never implemented here.
    function automatic logic [31:0] impl_mask_f();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i == 0) || (i == 2) || ((i >= 3) && (i <= NUM_HPM + 2));
        end
        return m;
    endfunction

    localparam logic [31:0] IMPL_MASK = impl_mask_f();

    logic [CNT_WIDTH-1:0] cnt_q [32];
    logic [CNT_WIDTH-1:0] cnt_d [32];
    logic [31:0]          inhibit_q;
    logic [31:0]          inhibit_d;
    logic [31:0]          counteren_q;
    logic [31:0]          counteren_d;
    logic [31:0]          inc_evt;

    logic                 is_mcnt;
    logic                 is_ucnt;
    logic                 is_cen;
    logic                 is_inh;
    logic                 is_hi;
    logic [4:0]           idx;
    logic                 user_ok;
    logic [63:0]          cnt_ext;

    // ------------------------------------------------------------------
    // Address decode
    // Counter spaces are 0xB00/0xB80 (machine) and 0xC00/0xC80 (user).
    // addr[7] selects the high half and addr[4:0] selects the slot.
    // ------------------------------------------------------------------
    assign idx     = addr[4:0];
    assign is_hi   = addr[7];
    assign is_mcnt = (addr[11:8] == 4'hB) && (addr[6:5] == 2'b00);
    assign is_ucnt = (addr[11:8] == 4'hC) && (addr[6:5] == 2'b00);
    assign is_cen  = (addr == 12'h306);
    assign is_inh  = (addr == 12'h320);
    assign user_ok = is_ucnt && counteren_q[idx];

    assign exists  = is_mcnt || is_ucnt || is_cen || is_inh;
    assign rdonly  = user_ok;
    assign priv    = user_ok ? 2'd0 : 2'd3;

    // Zero-extend to 64 bits so that the high half of a narrow counter reads
    // correctly. Unimplemented slots hold 0, so they read 0.
    assign cnt_ext = 64'(cnt_q[idx]);

    always_comb begin
        rdata = '0;
        if (is_mcnt || is_ucnt) begin
            rdata = is_hi ? cnt_ext[63:32] : cnt_ext[31:0];
        end else if (is_cen) begin
            rdata = counteren_q;
        end else if (is_inh) begin
            rdata = inhibit_q;
        end
    end

    // ------------------------------------------------------------------
    // Increment sources, indexed by counter slot
    // ------------------------------------------------------------------
    always_comb begin
        inc_evt    = '0;
        inc_evt[0] = 1'b1;
        inc_evt[2] = retire;
        for (int i = 0; i < NUM_HPM; i++) begin
            inc_evt[i+3] = evt[i];
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // Only the machine-space counters, mcounteren and mcountinhibit can be
    // written. The user shadows and unimplemented slots ignore we.
    // ------------------------------------------------------------------
    always_comb begin
        inhibit_d   = inhibit_q;
        counteren_d = counteren_q;
        if (we && is_inh) begin
            inhibit_d = wdata & IMPL_MASK;
        end
        if (we && is_cen) begin
            counteren_d = wdata & IMPL_MASK;
        end
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = '0;
            if (IMPL_MASK[i]) begin
                cnt_d[i] = cnt_q[i];
                if (we && is_mcnt && (idx == 5'(i))) begin
                    // The write replaces one half of the counter. The other
                    // half keeps its old value and the increment for this
                    // cycle is dropped.
                    if (is_hi) begin
                        cnt_d[i][CNT_WIDTH-1:32] = wdata[CNT_WIDTH-33:0];
                    end else begin
                        cnt_d[i][31:0] = wdata;
                    end
                end else if (inc_evt[i] && !inhibit_q[i]) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            inhibit_q   <= '0;
            counteren_q <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            inhibit_q   <= inhibit_d;
            counteren_q <= counteren_d;
        end
    end

endmodule

// File: doc/boa_csr_hpm.md
BOA_CSR_HPM -- requirements
Module: boa_csr_hpm

Interface
REQ-001 SHALL have parameter NUM_HPM, default 4, number of implemented mhpmcounterN (N=3..NUM_HPM+2), legal range 0..29.
REQ-002 SHALL have parameter CNT_WIDTH, default 64, implemented counter width, legal range 33..64.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port we  input  1  CSR write enable.
REQ-006 SHALL have port addr  input  12  CSR address.
REQ-007 SHALL have port wdata  input  32  CSR write data, already merged.
REQ-008 SHALL have port exists  output  1  addressed CSR is decoded by this block.
REQ-009 SHALL have port rdonly  output  1  addressed CSR is read-only.
REQ-010 SHALL have port priv  output  2  minimum privilege for the addressed CSR.
REQ-011 SHALL have port rdata  output  32  read data.
REQ-012 SHALL have port retire  input  1  one instruction retired this cycle.
REQ-013 SHALL have port evt  input  NUM_HPM  per-counter event pulse, bit i drives mhpmcounter(i+3).

Function
REQ-014 SHALL decode: mcycle 0xB00, minstret 0xB02, mhpmcounterN 0xB00+N; high halves at +0x80; user shadows at 0xC00/0xC80 equivalents; mcounteren 0x306; mcountinhibit 0x320.
REQ-015 SHALL drive exists=1 for every address in REQ-014, including N = NUM_HPM+3..31 and 0xB01/0xC01 (time slots), and exists=0 elsewhere with rdata=0.
REQ-016 SHALL drive rdonly=1 and priv=0 for user shadows when the matching mcounteren bit is 1; priv=3 when it is 0; all other decoded CSRs rdonly=0, priv=3.
REQ-017 SHALL return reads combinationally (latency 0): low half = cnt[31:0], high half = cnt[CNT_WIDTH-1:32] zero-extended.
REQ-018 SHALL read 0 and ignore writes for unimplemented counter slots and for 0xB01/0xB81; the time shadows 0xC01/0xC81 are read-only zero.
REQ-019 SHALL apply a write (we=1 on a writable CSR) at the next rising edge; reads in the write cycle return the pre-write value.
REQ-020 SHALL, on a write to a half, replace only that half; the other half keeps its old value, and the counter's increment in that cycle is discarded.
REQ-021 SHALL increment mcycle every cycle, minstret when retire=1, and mhpmcounterN when evt[N-3]=1, each only if mcountinhibit bit N is 0.
REQ-022 SHALL wrap counters modulo 2^CNT_WIDTH, carrying from bit 31 into the high half in the same cycle.
REQ-023 SHALL implement mcountinhibit and mcounteren bits 0, 2, 3..NUM_HPM+2 as writable; bit 1 and unimplemented bits SHALL read 0.
REQ-024 SHALL ignore we on read-only or non-existent addresses.

Reset
REQ-025 SHALL, while rst=1, asynchronously clear all counters, mcountinhibit and mcounteren to 0; combinational outputs follow from the cleared state.
REQ-026 SHALL begin counting on the first rising edge after rst deasserts; a write pending during rst is lost.

Verification
REQ-027 Reset release, no writes, 10 cycles -> read 0xB00 = 10, 0xB80 = 0, 0xB02 = 0.
REQ-028 Write 0xB00 = 0xFFFFFFFF, then 1 idle cycle -> 0xB00 = 0, 0xB80 = 1 (carry); with CNT_WIDTH=33, 0xB80 = 0x1 and a further 2^32 cycles wrap to 0.
REQ-029 Write mcountinhibit = 0x8, pulse evt[0] 5 cycles -> 0xB03 = 0; write 0x0, pulse evt[0] 5 cycles -> 0xB03 = 5.
REQ-030 mcounteren = 0 -> addr 0xC00 gives priv=3; write mcounteren = 0x1 -> priv=0, rdonly=1, rdata equals 0xB00.
REQ-031 retire=1 in the same cycle as write 0xB02 = 100 -> 0xB02 = 100 next cycle (increment discarded), 101 after another retire.
REQ-032 NUM_HPM=4: addr 0xB08 -> exists=1, rdata=0; write 0xB08 = 5 -> still 0; addr 0x7C0 -> exists=0.
